// File: rtl/qpix_pkg.sv
// Shared QPix readout definitions: serial-readout FSM encoding and default
// frame geometry used by the SIPO readout path.
package qpix_pkg;

  // Bits per lane in one readout frame
  localparam int QPIX_NBITS = 32;

  // Half-period of the chip serial clock, in fabric clock cycles
  localparam int QPIX_SER_DIV = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_SETUP = 3'd1,
    LOAD_HI    = 3'd2,
    SHIFT_LO   = 3'd3,
    SHIFT_HI   = 3'd4,
    DONE       = 3'd5
  } sipo_state_t;

  // States in which the chip serial clock is high
  function automatic logic ser_clk_high(input sipo_state_t s);
    return (s == LOAD_HI) || (s == SHIFT_HI);
  endfunction

  // States in which the chip is told to shift rather than load
  function automatic logic ser_cnt_shift(input sipo_state_t s);
    return (s == SHIFT_LO) || (s == SHIFT_HI);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow, level-type signals crossing into the clk
// domain (DataOut lanes, oLVDS, deltaT). Each bit is synchronized on its own,
// so multi-bit buses must only be sampled once they are known to be stable.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sipo_readout.sv
// QPix serial-out readback: generates the chip serial clock and serialOutCnt,
// issues one load pulse followed by NBITS shift pulses, and captures DataOut1/2
// MSB-first into two parallel words.
// Optional feature: define SIPO_FRAME_CNT_EN to add a 16-bit wrapping count of
// completed frames on port frame_cnt.
module sipo_readout
  import qpix_pkg::*;
#(
  parameter int NBITS   = QPIX_NBITS,
  parameter int CLK_DIV = QPIX_SER_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_din1,
  input  logic             ser_din2,
  output logic             ser_clk_out,
  output logic             ser_cnt_out,
  output logic [NBITS-1:0] data_out1,
  output logic [NBITS-1:0] data_out2,
  output logic             valid,
  output logic             busy
`ifdef SIPO_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int BCW = $clog2(NBITS + 1);
  localparam logic [7:0]     PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(NBITS - 1);

  sipo_state_t    state;
  sipo_state_t    state_next;
  logic [7:0]     phase;
  logic [BCW-1:0] bit_cnt;
  logic           start_q;
  logic           start_edge;
  logic           phase_done;
  logic           sample_en;
  logic           ser_clk_next;
  logic           ser_cnt_next;
  logic [1:0]     din_sync;
  logic [NBITS-1:0] shift1;
  logic [NBITS-1:0] shift2;

  // Lane data is asynchronous to clk; CLK_DIV >= 3 leaves time for it to settle
  sync_2ff #(
    .WIDTH(2)
  ) u_din_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ser_din2, ser_din1}),
    .q   (din_sync)
  );

  assign start_edge = start & ~start_q;
  assign phase_done = (phase == PHASE_LAST);
  assign sample_en  = (state == SHIFT_LO) && phase_done;
  assign valid      = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);

  // Next-state logic and the pin levels that the next state will drive
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start_edge) state_next = LOAD_SETUP;
      LOAD_SETUP: if (phase_done) state_next = LOAD_HI;
      LOAD_HI:    if (phase_done) state_next = SHIFT_LO;
      SHIFT_LO:   if (phase_done) state_next = SHIFT_HI;
      SHIFT_HI:   if (phase_done) state_next = (bit_cnt == BIT_LAST) ? DONE : SHIFT_LO;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    ser_clk_next = ser_clk_high(state_next);
    ser_cnt_next = ser_cnt_shift(state_next);
  end

  // State, phase and bit counters; pins are registered so the chip never sees decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      start_q     <= 1'b0;
      ser_clk_out <= 1'b0;
      ser_cnt_out <= 1'b0;
    end else begin
      state       <= state_next;
      start_q     <= start;
      ser_clk_out <= ser_clk_next;
      ser_cnt_out <= ser_cnt_next;
      if ((state_next == state) && (state != IDLE))
        phase <= phase + 8'd1;
      else
        phase <= '0;
      if (state == IDLE)
        bit_cnt <= '0;
      else if ((state == SHIFT_HI) && phase_done)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Sample both lanes at the end of each low phase, first bit ends up in the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift1 <= '0;
      shift2 <= '0;
    end else if (sample_en) begin
      shift1 <= {shift1[NBITS-2:0], din_sync[0]};
      shift2 <= {shift2[NBITS-2:0], din_sync[1]};
    end
  end

  // Publish whole words on entry to DONE so they change together with valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out1 <= '0;
      data_out2 <= '0;
    end else if (state_next == DONE) begin
      data_out1 <= shift1;
      data_out2 <= shift2;
    end
  end

`ifdef SIPO_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter, stepping in the same cycle as the data words
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt_r <= '0;
    else if (state_next == DONE)
      frame_cnt_r <= frame_cnt_r + 16'd1;
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_sipo_readout.sv
// Bench for sipo_readout: a behavioural QPix shift-register model feeds both
// lanes, a scoreboard holds the words each frame should deliver, and scenario
// tasks check pin timing, reset behaviour and start-edge handling.
// Build with SIPO_FRAME_CNT_EN defined to also exercise frame_cnt.
`timescale 1ns/1ps
module tb_sipo_readout;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, din1 = 1'b0, din2 = 1'b0;
  logic start8 = 1'b0, d81 = 1'b0, d82 = 1'b0;

  logic        ser_clk, ser_cnt, valid, busy;
  logic [31:0] data_out1, data_out2;
  logic        ser_clk8, ser_cnt8, valid8, busy8;
  logic [7:0]  data8_1, data8_2;
`ifdef SIPO_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt8;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sipo_readout dut (
    .clk(clk), .rst(rst), .start(start), .ser_din1(din1), .ser_din2(din2),
    .ser_clk_out(ser_clk), .ser_cnt_out(ser_cnt),
    .data_out1(data_out1), .data_out2(data_out2), .valid(valid), .busy(busy)
`ifdef SIPO_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  sipo_readout #(.NBITS(8), .CLK_DIV(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ser_din1(d81), .ser_din2(d82),
    .ser_clk_out(ser_clk8), .ser_cnt_out(ser_cnt8),
    .data_out1(data8_1), .data_out2(data8_2), .valid(valid8), .busy(busy8)
`ifdef SIPO_FRAME_CNT_EN
    , .frame_cnt(frame_cnt8)
`endif
  );

  // 50 MHz fabric clock
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: load on the pulse with serialOutCnt low, shift on the others
  logic [31:0] pat1 = '0, pat2 = '0, chip1 = '0, chip2 = '0;
  logic [7:0]  pat81 = '0, pat82 = '0, chip81 = '0, chip82 = '0;
  logic        glitch_mode = 1'b0;

  always @(posedge ser_clk) begin
    #3;
    if (!ser_cnt) begin
      chip1 = pat1;
      chip2 = pat2;
    end else begin
      chip1 = chip1 << 1;
      chip2 = chip2 << 1;
    end
    din1 = chip1[31];
    din2 = chip2[31];
    if (glitch_mode && ser_cnt) begin
      repeat (3) begin
        #8;
        din1 = ~din1;
        din2 = ~din2;
        #8;
        din1 = chip1[31];
        din2 = chip2[31];
      end
    end
  end

  // Wrong-level pulse straddling the SHIFT_LO sample edge; the sync stage must hide it
  always @(negedge ser_clk) begin
    #1;
    if (glitch_mode && ser_cnt) begin
      #64;
      din1 = ~chip1[31];
      din2 = ~chip2[31];
      #20;
      din1 = chip1[31];
      din2 = chip2[31];
    end
  end

  always @(posedge ser_clk8) begin
    #3;
    if (!ser_cnt8) begin
      chip81 = pat81;
      chip82 = pat82;
    end else begin
      chip81 = chip81 << 1;
      chip82 = chip82 << 1;
    end
    d81 = chip81[7];
    d82 = chip82[7];
  end

  // Scoreboards
  logic [31:0] exp1_q[$], exp2_q[$];
  logic [7:0]  exp81_q[$], exp82_q[$];
  logic [15:0] expfc_q[$];

  // Pin activity counters
  logic prev_sclk = 1'b0, prev_sclk8 = 1'b0;
  int rises = 0, shift_rises = 0, busy_cyc = 0, cnt_cyc = 0, valid_cnt = 0, last_valid_cyc = 0;
  int rises8 = 0, busy8_cyc = 0, valid8_cnt = 0, last_valid8_cyc = 0;

  always @(negedge clk) begin
    logic [31:0] e1, e2;
    if (ser_clk && !prev_sclk) begin
      rises++;
      if (ser_cnt) shift_rises++;
    end
    prev_sclk = ser_clk;
    if (busy) busy_cyc++;
    if (ser_cnt) cnt_cyc++;
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      vectors++;
      if (exp1_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_valid at cycle %0d: no frame expected", cyc);
      end else begin
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        if (data_out1 !== e1) begin
          miscompares++;
          $display("[TB] FAIL sb_data_out1 got %h expected %h", data_out1, e1);
        end
        vectors++;
        if (data_out2 !== e2) begin
          miscompares++;
          $display("[TB] FAIL sb_data_out2 got %h expected %h", data_out2, e2);
        end
      end
`ifdef SIPO_FRAME_CNT_EN
      if (expfc_q.size() != 0) begin
        logic [15:0] ef;
        ef = expfc_q.pop_front();
        vectors++;
        if (frame_cnt !== ef) begin
          miscompares++;
          $display("[TB] FAIL sb_frame_cnt got %h expected %h", frame_cnt, ef);
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    logic [7:0] e1, e2;
    if (ser_clk8 && !prev_sclk8) rises8++;
    prev_sclk8 = ser_clk8;
    if (busy8) busy8_cyc++;
    if (valid8) begin
      valid8_cnt++;
      last_valid8_cyc = cyc;
      vectors++;
      if (exp81_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb8_unexpected_valid at cycle %0d", cyc);
      end else begin
        e1 = exp81_q.pop_front();
        e2 = exp82_q.pop_front();
        if (data8_1 !== e1) begin
          miscompares++;
          $display("[TB] FAIL sb8_data_out1 got %h expected %h", data8_1, e1);
        end
        vectors++;
        if (data8_2 !== e2) begin
          miscompares++;
          $display("[TB] FAIL sb8_data_out2 got %h expected %h", data8_2, e2);
        end
      end
    end
  end

  // Raise start on the main instance and record what the frame must deliver
  task automatic kick_main(input logic [31:0] p1, input logic [31:0] p2, output int drive);
    @(negedge clk);
    pat1 = p1;
    pat2 = p2;
    exp1_q.push_back(p1);
    exp2_q.push_back(p2);
    drive = cyc;
    start = 1'b1;
  endtask

  task automatic wait_main_valid(input int base, input int budget);
    for (int i = 0; i < budget && valid_cnt == base; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (ser_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ser_clk got %b expected 0", ser_clk); end
    vectors++; if (ser_cnt !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ser_cnt got %b expected 0", ser_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b expected 0", busy); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %b expected 0", valid); end
    vectors++; if (data_out1 !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_data_out1 got %h expected 0", data_out1); end
    vectors++; if (data_out2 !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_data_out2 got %h expected 0", data_out2); end
    vectors++; if ({ser_clk8, ser_cnt8, busy8, valid8} !== 4'b0) begin miscompares++; $display("[TB] FAIL rst_dut8_ctrl got %b expected 0000", {ser_clk8, ser_cnt8, busy8, valid8}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_basic_frame();
    int drive, b_r, b_sr, b_cnt, b_busy, b_val;
    $display("[TB] test_basic_frame");
    b_r = rises; b_sr = shift_rises; b_cnt = cnt_cyc; b_busy = busy_cyc; b_val = valid_cnt;
    kick_main(32'hA5A5_1234, 32'h0F0F_F0F0, drive);
    wait_main_valid(b_val, 400);
    repeat (5) @(negedge clk);
    start = 1'b0;
    vectors++; if (valid_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL basic_valid_pulses got %0d expected 1", valid_cnt - b_val); end
    vectors++; if (last_valid_cyc - drive !== 265) begin miscompares++; $display("[TB] FAIL basic_valid_latency got %0d expected 265", last_valid_cyc - drive); end
    vectors++; if (rises - b_r !== 33) begin miscompares++; $display("[TB] FAIL basic_ser_clk_rises got %0d expected 33", rises - b_r); end
    vectors++; if (shift_rises - b_sr !== 32) begin miscompares++; $display("[TB] FAIL basic_shift_pulses got %0d expected 32", shift_rises - b_sr); end
    vectors++; if (cnt_cyc - b_cnt !== 256) begin miscompares++; $display("[TB] FAIL basic_ser_cnt_cycles got %0d expected 256", cnt_cyc - b_cnt); end
    vectors++; if (busy_cyc - b_busy !== 264) begin miscompares++; $display("[TB] FAIL basic_busy_cycles got %0d expected 264", busy_cyc - b_busy); end
  endtask

  task automatic test_start_held();
    int drive, b_r, b_val, b_busy;
    $display("[TB] test_start_held");
    b_r = rises; b_val = valid_cnt; b_busy = busy_cyc;
    kick_main(32'h3C3C_5AA5, 32'hDEAD_BEEF, drive);
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (i == 99) start = 1'b0;
      if (i == 100) start = 1'b1;
      if (i == 300) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL held_busy_after_frame got %b expected 0", busy); end
      end
    end
    start = 1'b0;
    vectors++; if (valid_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL held_valid_pulses got %0d expected 1", valid_cnt - b_val); end
    vectors++; if (rises - b_r !== 33) begin miscompares++; $display("[TB] FAIL held_ser_clk_rises got %0d expected 33", rises - b_r); end
    vectors++; if (last_valid_cyc - drive !== 265) begin miscompares++; $display("[TB] FAIL held_valid_latency got %0d expected 265", last_valid_cyc - drive); end
    vectors++; if (busy_cyc - b_busy !== 264) begin miscompares++; $display("[TB] FAIL held_busy_cycles got %0d expected 264", busy_cyc - b_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int drive, b_sr, b_r, b_val;
    $display("[TB] test_reset_mid_frame");
    b_sr = shift_rises;
    kick_main(32'hCAFE_0001, 32'h0000_BEEF, drive);
    for (int i = 0; i < 400 && shift_rises - b_sr < 10; i++) @(negedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    vectors++; if (ser_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ser_clk got %b expected 0", ser_clk); end
    vectors++; if (ser_cnt !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ser_cnt got %b expected 0", ser_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
    vectors++; if (data_out1 !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_data_out1 got %h expected 0", data_out1); end
    vectors++; if (data_out2 !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_data_out2 got %h expected 0", data_out2); end
    exp1_q.delete();
    exp2_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    b_r = rises; b_val = valid_cnt;
    kick_main(32'h1234_5678, 32'h8765_4321, drive);
    wait_main_valid(b_val, 400);
    repeat (5) @(negedge clk);
    start = 1'b0;
    vectors++; if (valid_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL postrst_valid_pulses got %0d expected 1", valid_cnt - b_val); end
    vectors++; if (rises - b_r !== 33) begin miscompares++; $display("[TB] FAIL postrst_ser_clk_rises got %0d expected 33", rises - b_r); end
  endtask

  task automatic test_param_variant();
    int drive, b_r, b_val, b_busy;
    $display("[TB] test_param_variant");
    b_r = rises8; b_val = valid8_cnt; b_busy = busy8_cyc;
    @(negedge clk);
    pat81 = 8'h81;
    pat82 = 8'h7E;
    exp81_q.push_back(8'h81);
    exp82_q.push_back(8'h7E);
    drive = cyc;
    start8 = 1'b1;
    for (int i = 0; i < 200 && valid8_cnt == b_val; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    start8 = 1'b0;
    vectors++; if (valid8_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL p8_valid_pulses got %0d expected 1", valid8_cnt - b_val); end
    vectors++; if (last_valid8_cyc - drive !== 55) begin miscompares++; $display("[TB] FAIL p8_valid_latency got %0d expected 55", last_valid8_cyc - drive); end
    vectors++; if (rises8 - b_r !== 9) begin miscompares++; $display("[TB] FAIL p8_ser_clk_rises got %0d expected 9", rises8 - b_r); end
    vectors++; if (busy8_cyc - b_busy !== 54) begin miscompares++; $display("[TB] FAIL p8_busy_cycles got %0d expected 54", busy8_cyc - b_busy); end
  endtask

  task automatic test_async_din();
    int drive, b_val;
    $display("[TB] test_async_din");
    b_val = valid_cnt;
    glitch_mode = 1'b1;
    kick_main(32'hFFFF_0000, 32'h0000_FFFF, drive);
    wait_main_valid(b_val, 400);
    repeat (5) @(negedge clk);
    start = 1'b0;
    glitch_mode = 1'b0;
    vectors++; if (valid_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL async_valid_pulses got %0d expected 1", valid_cnt - b_val); end
    vectors++; if ($isunknown({data_out1, data_out2})) begin miscompares++; $display("[TB] FAIL async_x_free got %h_%h expected no X", data_out1, data_out2); end
  endtask

  task automatic test_done_edge_ignored();
    int drive, b_r, b_val;
    $display("[TB] test_done_edge_ignored");
    b_r = rises; b_val = valid_cnt;
    kick_main(32'h0123_4567, 32'h89AB_CDEF, drive);
    repeat (3) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && valid !== 1'b1; i++) @(negedge clk);
    start = 1'b1;
    repeat (300) @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL done_edge_busy got %b expected 0", busy); end
    vectors++; if (valid_cnt - b_val !== 1) begin miscompares++; $display("[TB] FAIL done_edge_valid_pulses got %0d expected 1", valid_cnt - b_val); end
    vectors++; if (rises - b_r !== 33) begin miscompares++; $display("[TB] FAIL done_edge_ser_clk_rises got %0d expected 33", rises - b_r); end
  endtask

  task automatic test_back_to_back();
    int drive, drive2, b_r, b_val;
    $display("[TB] test_back_to_back");
    b_r = rises; b_val = valid_cnt;
    kick_main(32'h5555_AAAA, 32'h8000_0001, drive);
    repeat (3) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && valid !== 1'b1; i++) @(negedge clk);
    kick_main(32'h7FFF_FFFE, 32'hF000_000F, drive2);
    wait_main_valid(b_val + 1, 400);
    repeat (5) @(negedge clk);
    start = 1'b0;
    vectors++; if (valid_cnt - b_val !== 2) begin miscompares++; $display("[TB] FAIL b2b_valid_pulses got %0d expected 2", valid_cnt - b_val); end
    vectors++; if (last_valid_cyc - drive2 !== 265) begin miscompares++; $display("[TB] FAIL b2b_second_latency got %0d expected 265", last_valid_cyc - drive2); end
    vectors++; if (rises - b_r !== 66) begin miscompares++; $display("[TB] FAIL b2b_ser_clk_rises got %0d expected 66", rises - b_r); end
  endtask

`ifdef SIPO_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int drive, b_val;
    logic [15:0] ef;
    $display("[TB] test_frame_cnt");
    @(negedge clk);
    force dut.frame_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_r;
    ef = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      expfc_q.push_back(ef);
      ef = ef + 16'd1;
    end
    for (int k = 0; k < 3; k++) begin
      b_val = valid_cnt;
      kick_main(32'hA5A5_1234 ^ 32'(k), 32'h0F0F_F0F0, drive);
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_main_valid(b_val, 400);
      repeat (3) @(negedge clk);
    end
    vectors++; if (expfc_q.size() != 0) begin miscompares++; $display("[TB] FAIL fc_steps_seen got %0d pending expected 0", expfc_q.size()); end
    vectors++; if (frame_cnt !== 16'h0001) begin miscompares++; $display("[TB] FAIL fc_final got %h expected 0001", frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_start_held();
    test_reset_mid_frame();
    test_param_variant();
    test_async_din();
    test_done_edge_ignored();
    test_back_to_back();
`ifdef SIPO_FRAME_CNT_EN
    test_frame_cnt();
`endif
    vectors++;
    if (exp1_q.size() != 0 || exp81_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_leftover got %0d/%0d frames expected 0/0", exp1_q.size(), exp81_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if some scenario stalls
  initial begin
    #400000;
    miscompares++;
    $display("[TB] FAIL watchdog reached %0d cycles expected completion earlier", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

endmodule
